// File: rtl/riscv_mc_controller.sv
// rtl/riscv_mc_controller.sv - multicycle RV32I control FSM with ready-handshake memory port
module riscv_mc_controller #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int ALU_CTRL_W    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  Zero,
  input  logic                  MemReady,
  output logic                  MemReq,
  output logic                  MemWrite,
  output logic                  AdrSrc,
  output logic                  IRWrite,
  output logic                  PCWrite,
  output logic                  RegWrite,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [2:0]            ImmSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  Illegal
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWRITE, S_MEMWB, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LINK, S_LUI, S_ILLEGAL
  } state_t;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R    = 7'b0110011,
                         OP_I    = 7'b0010011, OP_BR    = 7'b1100011, OP_JAL  = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI   = 7'b0110111, OP_AUIPC = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100;

  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR  = 3'b011,
                         ALU_XOR = 3'b100, ALU_SLT = 3'b101, ALU_SLL = 3'b110, ALU_SRL = 3'b111;

  state_t     state;
  logic       ready;
  logic       alu_bad;
  logic       br_bad;
  logic [2:0] alu;

  assign ready   = MEM_HANDSHAKE ? MemReady : 1'b1;
  // sltu and sra have no ALU encoding, so they trap rather than execute wrongly
  assign alu_bad = (funct3 == 3'b011) || ((funct3 == 3'b101) && funct7b5);
  assign br_bad  = (funct3[2:1] != 2'b00);

  function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic f7, input logic is_r);
    case (f3)
      3'b000:  alu_dec = (is_r && f7) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_dec = ALU_SLL;
      3'b010:  alu_dec = ALU_SLT;
      3'b100:  alu_dec = ALU_XOR;
      3'b101:  alu_dec = ALU_SRL;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    if (ready) state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LOAD, OP_STORE: state <= S_MEMADR;
            OP_R:              state <= S_EXECR;
            OP_I:              state <= S_EXECI;
            OP_BR:             state <= S_BRANCH;
            OP_JAL:            state <= S_JAL;
            OP_JALR:           state <= S_JALR;
            OP_LUI:            state <= S_LUI;
            OP_AUIPC:          state <= S_ALUWB;
            default:           state <= S_ILLEGAL;
          endcase
        end
        S_MEMADR:   state <= op[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (ready) state <= S_MEMWB;
        S_MEMWRITE: if (ready) state <= S_FETCH;
        S_MEMWB, S_ALUWB, S_LUI: state <= S_FETCH;
        S_EXECR, S_EXECI: state <= alu_bad ? S_ILLEGAL : S_ALUWB;
        S_BRANCH:   state <= br_bad ? S_ILLEGAL : S_FETCH;
        S_JAL:      state <= S_ALUWB;
        S_JALR:     state <= S_LINK;
        S_LINK:     state <= S_ALUWB;
        S_ILLEGAL:  state <= S_ILLEGAL;
        default:    state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ImmSrc    = IMM_I;
    alu       = ALU_ADD;
    Illegal   = 1'b0;
    case (state)
      S_FETCH: begin
        MemReq    = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = ready;
        PCWrite   = ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_BR:           ImmSrc = IMM_B;
          OP_JAL:          ImmSrc = IMM_J;
          OP_AUIPC, OP_LUI: ImmSrc = IMM_U;
          default:         ImmSrc = IMM_I;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = op[5] ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
      end
      S_MEMWRITE: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu     = alu_dec(funct3, funct7b5, 1'b1);
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu     = alu_dec(funct3, funct7b5, 1'b0);
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        alu     = ALU_SUB;
        PCWrite = !br_bad && (Zero ^ funct3[0]);
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      S_JALR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      S_LINK: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
      end
      S_LUI: begin
        ImmSrc    = IMM_U;
        ResultSrc = 2'b11;
        RegWrite  = 1'b1;
      end
      S_ILLEGAL: Illegal = 1'b1;
      default: ;
    endcase
    // async reset forces FETCH, whose Moore outputs would otherwise request memory
    if (reset) begin
      MemReq   = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
      Illegal  = 1'b0;
    end
  end

  always_comb begin
    ALUControl      = '0;
    ALUControl[2:0] = alu;
  end

endmodule

// File: tb/tb_riscv_mc_controller.sv
// tb/tb_riscv_mc_controller.sv - directed and randomized checks of riscv_mc_controller
module tb_riscv_mc_controller;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc, ALUControl;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  riscv_mc_controller #(.MEM_HANDSHAKE(1'b1), .ALU_CTRL_W(3)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .MemReady(MemReady), .MemReq(MemReq), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .Illegal(Illegal)
  );

  int          cyc, mreq_n, mwr_n;
  logic        saw_ill, timeout;
  logic [63:0] irw_bits, rw_bits, pcw_bits;
  logic [2:0]  alu_tr [64];
  logic [1:0]  rs_tr [64];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts in the low clock phase with FETCH showing; returns at the next FETCH or at ILLEGAL.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input int fw, input int mw);
    int fcnt, mcnt;
    logic left;
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    cyc = 0; mreq_n = 0; mwr_n = 0; saw_ill = 0; timeout = 0;
    irw_bits = '0; rw_bits = '0; pcw_bits = '0;
    fcnt = 0; mcnt = 0; left = 0;
    forever begin
      if (Illegal) begin saw_ill = 1; break; end
      if (left && MemReq && !AdrSrc) break;
      if (cyc >= 64) begin timeout = 1; break; end
      if (MemReq && !AdrSrc) begin MemReady = (fcnt >= fw); fcnt++; end
      else if (MemReq) begin MemReady = (mcnt >= mw); mcnt++; left = 1; end
      else begin MemReady = 1'($urandom_range(0, 1)); left = 1; end
      #1;
      irw_bits[cyc] = IRWrite;
      rw_bits[cyc]  = RegWrite;
      pcw_bits[cyc] = PCWrite;
      mreq_n += int'(MemReq);
      mwr_n  += int'(MemWrite);
      alu_tr[cyc] = ALUControl;
      rs_tr[cyc]  = ResultSrc;
      cyc++;
      @(negedge clk);
    end
  endtask

  // Reference: instruction class -> cycle budget and strobe totals.
  function automatic void model(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                input logic z, input int fw, input int mw,
                                output int e_cyc, output logic e_ill, output int e_rw,
                                output int e_pcw, output int e_mreq, output int e_mwr,
                                output logic [1:0] e_rs, output logic e_has_alu,
                                output logic [2:0] e_alu);
    logic [2:0] alu_tab [8];
    logic ld, st, r, i, br, jal, jalr, lui, auipc, known;
    alu_tab = '{3'd0, 3'd6, 3'd5, 3'd0, 3'd4, 3'd7, 3'd3, 3'd2};
    ld = (o == 7'h03); st = (o == 7'h23); r = (o == 7'h33); i = (o == 7'h13);
    br = (o == 7'h63); jal = (o == 7'h6f); jalr = (o == 7'h67); lui = (o == 7'h37);
    auipc = (o == 7'h17);
    known = ld | st | r | i | br | jal | jalr | lui | auipc;
    e_ill = !known || ((r || i) && (f3 == 3 || (f3 == 5 && f7))) || (br && f3 > 1);
    e_rs = ld ? 2'b01 : (lui ? 2'b11 : 2'b00);
    e_has_alu = !e_ill && (r || i);
    e_alu = (r && f3 == 0 && f7) ? 3'd1 : alu_tab[f3];
    e_mreq = fw + 1 + ((ld || st) ? mw + 1 : 0);
    e_mwr = st ? mw + 1 : 0;
    if (e_ill) begin
      e_cyc = fw + (known ? 3 : 2);
      e_rw = 0; e_pcw = 1;
    end else begin
      e_cyc = fw + ((lui || br || auipc) ? 3 : ((ld || jalr) ? 5 : 4)) + ((ld || st) ? mw : 0);
      e_rw = (st || br) ? 0 : 1;
      e_pcw = 1 + ((jal || jalr) ? 1 : 0) + ((br && (z ^ f3[0])) ? 1 : 0);
    end
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    MemReady = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    logic [6:0] pool [10];
    logic [6:0] o;
    logic [2:0] f3;
    logic f7, z, e_ill, e_has_alu;
    logic [1:0] e_rs;
    logic [2:0] e_alu;
    int fw, mw, e_cyc, e_rw, e_pcw, e_mreq, e_mwr;
    pool = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h7f};

    #2;
    check("reset_strobes", {MemReq, MemWrite, IRWrite, PCWrite, RegWrite, Illegal}, 6'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_fetch", {MemReq, AdrSrc, ALUSrcB, ResultSrc}, {1'b1, 1'b0, 2'b10, 2'b10});

    // reset while a load waits in MEMREAD
    op = 7'h03; MemReady = 1'b1;
    @(negedge clk); MemReady = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    check("memread_reached", {MemReq, AdrSrc, MemWrite}, 3'b110);
    reset = 1'b1; #1;
    check("reset_drops_memreq", {MemReq, IRWrite, Illegal}, 3'b000);
    @(negedge clk); reset = 1'b0; #1;
    check("after_reset_fetch", {MemReq, AdrSrc, Illegal}, 3'b100);

    run_instr(7'h33, 3'b000, 1'b0, 1'b0, 0, 0);
    check("add_cycles", 64'(cyc), 64'd4);
    check("add_irw", irw_bits, 64'b0001);
    check("add_rw", rw_bits, 64'b1000);
    check("add_alu", 64'(alu_tr[2]), 64'd0);

    run_instr(7'h03, 3'b010, 1'b0, 1'b0, 2, 3);
    check("lw_cycles", 64'(cyc), 64'd10);
    check("lw_irw", irw_bits, 64'b100);
    check("lw_rw", rw_bits, 64'h200);
    check("lw_rs", 64'(rs_tr[9]), 64'd1);

    run_instr(7'h63, 3'b001, 1'b0, 1'b0, 0, 0);
    check("bne_taken", {pcw_bits, 64'(cyc)}, {64'b101, 64'd3});
    run_instr(7'h63, 3'b001, 1'b0, 1'b1, 0, 0);
    check("bne_not_taken", {pcw_bits, 64'(cyc)}, {64'b001, 64'd3});

    run_instr(7'h67, 3'b000, 1'b0, 1'b0, 0, 0);
    check("jalr_cycles", 64'(cyc), 64'd5);
    check("jalr_pcw", pcw_bits, 64'b00101);
    check("jalr_rs", 64'(rs_tr[2]), 64'd2);
    check("jalr_rw", rw_bits, 64'b10000);

    run_instr(7'h7f, 3'b000, 1'b0, 1'b0, 0, 0);
    check("ill_entry", {63'(cyc), saw_ill}, {63'd2, 1'b1});
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      MemReady = 1'($urandom_range(0, 1));
      #1;
      check("ill_sticky", {Illegal, MemReq, MemWrite, IRWrite, PCWrite, RegWrite}, 6'b100000);
    end
    do_reset();
    check("ill_cleared", {Illegal, MemReq}, 2'b01);

    for (int n = 0; n < 40; n++) begin
      int pick;
      pick = $urandom_range(0, 10);
      o = (pick == 10) ? 7'($urandom_range(0, 127)) : pool[pick];
      f3 = 3'($urandom_range(0, 7));
      f7 = 1'($urandom_range(0, 1));
      z = 1'($urandom_range(0, 1));
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 3);
      model(o, f3, f7, z, fw, mw, e_cyc, e_ill, e_rw, e_pcw, e_mreq, e_mwr, e_rs, e_has_alu, e_alu);
      run_instr(o, f3, f7, z, fw, mw);
      check($sformatf("rnd%0d_op%0h_ill", n, o), {timeout, saw_ill}, {1'b0, e_ill});
      check($sformatf("rnd%0d_op%0h_cyc", n, o), 64'(cyc), 64'(e_cyc));
      check($sformatf("rnd%0d_irw", n), 64'($countones(irw_bits)), 64'd1);
      check($sformatf("rnd%0d_rw", n), 64'($countones(rw_bits)), 64'(e_rw));
      check($sformatf("rnd%0d_pcw", n), 64'($countones(pcw_bits)), 64'(e_pcw));
      check($sformatf("rnd%0d_mreq", n), 64'(mreq_n), 64'(e_mreq));
      check($sformatf("rnd%0d_mwr", n), 64'(mwr_n), 64'(e_mwr));
      if (!e_ill && e_rw == 1 && cyc > 0)
        check($sformatf("rnd%0d_rs", n), 64'(rs_tr[cyc-1]), 64'(e_rs));
      if (e_has_alu)
        check($sformatf("rnd%0d_alu_f3%0d", n, f3), 64'(alu_tr[fw+2]), 64'(e_alu));
      if (saw_ill || timeout) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
